// File: rtl/multicycle_shifter.sv
// rtl/multicycle_shifter.sv - iterative SLL/SRL/SRA/ROTL unit shifting up to STEP bits per clock
module multicycle_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W + 1)'(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_d;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] rem_d;
    logic [1:0]         op_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   data_q;

    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W:0]   rot_amt;

    // SRA keeps the captured sign bit in work_q's MSB, so each partial
    // arithmetic step refills with the original bit WIDTH-1.
    always_comb begin
        step_amt = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHAMT_W-1:0];
        rot_amt  = WIDTH_W - {1'b0, step_amt};
        rem_d    = rem_q - step_amt;
        work_d   = work_q;
        case (op_q)
            OP_SLL:  work_d = work_q << step_amt;
            OP_SRL:  work_d = work_q >> step_amt;
            OP_SRA:  work_d = $unsigned($signed(work_q) >>> step_amt);
            OP_ROTL: work_d = (work_q << step_amt) | (work_q >> rot_amt);
            default: work_d = work_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        work_q  <= data_i;
                        rem_q   <= shamt_i;
                        op_q    <= mode_i;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (rem_q != '0) begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                    end else begin
                        data_q  <= work_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// tb/tb_multicycle_shifter.sv - randomized and directed checks of multicycle_shifter at STEP=4, 1 and 32
module tb_multicycle_shifter;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [4:0]  shamt_i;
    logic [31:0] data_i;

    logic        busy_a, done_a;
    logic [31:0] data_a;
    logic        busy_b, done_b;
    logic [31:0] data_b;
    logic        busy_c, done_c;
    logic [31:0] data_c;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_shifter #(.WIDTH(32), .STEP(4)) dut_s4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .shamt_i(shamt_i), .data_i(data_i),
        .busy_o(busy_a), .done_o(done_a), .data_o(data_a)
    );

    multicycle_shifter #(.WIDTH(32), .STEP(1)) dut_s1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .shamt_i(shamt_i), .data_i(data_i),
        .busy_o(busy_b), .done_o(done_b), .data_o(data_b)
    );

    multicycle_shifter #(.WIDTH(32), .STEP(32)) dut_s32 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .shamt_i(shamt_i), .data_i(data_i),
        .busy_o(busy_c), .done_o(done_c), .data_o(data_c)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Bit-by-bit definition of each operation as a single shift by sh.
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input int sh, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'd0:    r[i] = (i >= sh) ? d[i - sh] : 1'b0;
                2'd1:    r[i] = (i + sh < 32) ? d[i + sh] : 1'b0;
                2'd2:    r[i] = (i + sh < 32) ? d[i + sh] : d[31];
                default: r[i] = d[(i - sh + 32) % 32];
            endcase
        end
        return r;
    endfunction

    // Issues one operation on the shared inputs and follows the STEP=4 unit to completion.
    task automatic run_op(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] d,
                          output logic [31:0] res, output int lat, output int busy_cnt,
                          output bit overlap);
        mode_i  = m;
        shamt_i = sh;
        data_i  = d;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        mode_i   = 2'($urandom);
        shamt_i  = 5'($urandom);
        data_i   = $urandom;
        res      = 'x;
        lat      = -1;
        busy_cnt = busy_a ? 1 : 0;
        overlap  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i); #1;
            if (busy_a && done_a) overlap = 1'b1;
            if (busy_a) busy_cnt++;
            if (done_a) begin
                lat = c;
                res = data_a;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_i   = 1'b1;
        start_i = 1'b0;
        mode_i  = 2'd0;
        shamt_i = 5'd0;
        data_i  = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
        n_checks++; if (data_a !== 32'd0) $display("FAIL reset_data got %h want 0", data_a); else n_pass++;
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  sh;
        logic [31:0] d;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed;
        vec_t v[8];
        logic [31:0] res;
        int lat, bc;
        bit ov;
        v[0] = '{2'd0, 5'd2,  32'h0000_0001, 32'h0000_0004, 2};
        v[1] = '{2'd2, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9};
        v[2] = '{2'd1, 5'd31, 32'h8000_0000, 32'h0000_0001, 9};
        v[3] = '{2'd3, 5'd4,  32'h8000_0001, 32'h0000_0018, 2};
        v[4] = '{2'd0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        v[5] = '{2'd1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        v[6] = '{2'd2, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        v[7] = '{2'd3, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].m, v[i].sh, v[i].d, res, lat, bc, ov);
            n_checks++; if (res !== v[i].exp) $display("FAIL dir%0d_data got %h want %h", i, res, v[i].exp); else n_pass++;
            n_checks++; if (lat != v[i].lat) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); else n_pass++;
            n_checks++; if (bc != v[i].lat) $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, v[i].lat); else n_pass++;
            n_checks++; if (ov) $display("FAIL dir%0d_busy_done_overlap got 1 want 0", i); else n_pass++;
            @(posedge clk_i); #1;
            n_checks++; if (done_a !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0", i, done_a); else n_pass++;
            n_checks++; if (data_a !== v[i].exp) $display("FAIL dir%0d_data_hold got %h want %h", i, data_a, v[i].exp); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        int first = -1;
        logic [31:0] res = 'x;
        mode_i  = 2'd0;
        shamt_i = 5'd8;
        data_i  = 32'h1234_5678;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (done_a) begin
                dones++;
                if (first < 0) begin
                    first = c;
                    res = data_a;
                end
            end
            // lands on the edge where the unit is still busy finishing
            if (c == 2) begin
                start_i = 1'b1;
                mode_i  = 2'd3;
                shamt_i = 5'd1;
                data_i  = 32'hFFFF_FFFF;
            end
        end
        n_checks++; if (dones != 1) $display("FAIL ignore_done_count got %0d want 1", dones); else n_pass++;
        n_checks++; if (res !== 32'h3456_7800) $display("FAIL ignore_data got %h want 34567800", res); else n_pass++;
        n_checks++; if (first != 3) $display("FAIL ignore_latency got %0d want 3", first); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL ignore_idle got busy=%b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int lat, bc;
        bit ov;
        run_op(2'd0, 5'd8, 32'h0000_00AB, res, lat, bc, ov);
        n_checks++; if (res !== 32'h0000_AB00) $display("FAIL b2b_first got %h want 0000ab00", res); else n_pass++;
        n_checks++; if (done_a !== 1'b1) $display("FAIL b2b_in_done_cycle got done=%b want 1", done_a); else n_pass++;
        run_op(2'd1, 5'd4, 32'h0000_00F0, res, lat, bc, ov);
        n_checks++; if (res !== 32'h0000_000F) $display("FAIL b2b_second got %h want 0000000f", res); else n_pass++;
        n_checks++; if (lat != 2) $display("FAIL b2b_latency got %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        mode_i  = 2'd2;
        shamt_i = 5'd20;
        data_i  = 32'h8765_4321;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL rstmid_done got %b want 0", done_a); else n_pass++;
        n_checks++; if (data_a !== 32'd0) $display("FAIL rstmid_data got %h want 0", data_a); else n_pass++;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_i); #1;
            if (done_a) dones++;
        end
        n_checks++; if (dones != 0) $display("FAIL rstmid_no_done got %0d pulses want 0", dones); else n_pass++;
    endtask

    task automatic test_sweep;
        logic [1:0]  m;
        logic [4:0]  sh;
        logic [31:0] d, exp;
        int la, lb, lc;
        logic [31:0] ra, rb, rc;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int t = 0; t < 40; t++) begin
            m  = 2'($urandom);
            sh = (t < 2) ? ((t == 0) ? 5'd0 : 5'd31) : 5'($urandom);
            d  = $urandom;
            exp = ref_shift(m, int'(sh), d);
            mode_i = m; shamt_i = sh; data_i = d; start_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            data_i  = ~d;
            la = -1; lb = -1; lc = -1;
            ra = 'x; rb = 'x; rc = 'x;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk_i); #1;
                if (done_a && la < 0) begin la = c; ra = data_a; end
                if (done_b && lb < 0) begin lb = c; rb = data_b; end
                if (done_c && lc < 0) begin lc = c; rc = data_c; end
                if (la > 0 && lb > 0 && lc > 0) break;
            end
            n_checks++; if (ra !== exp) $display("FAIL sweep%0d_s4_data m=%0d sh=%0d got %h want %h", t, m, sh, ra, exp); else n_pass++;
            n_checks++; if (rb !== exp) $display("FAIL sweep%0d_s1_data m=%0d sh=%0d got %h want %h", t, m, sh, rb, exp); else n_pass++;
            n_checks++; if (rc !== exp) $display("FAIL sweep%0d_s32_data m=%0d sh=%0d got %h want %h", t, m, sh, rc, exp); else n_pass++;
            n_checks++; if (la != 1 + (int'(sh) + 3) / 4) $display("FAIL sweep%0d_s4_latency got %0d want %0d", t, la, 1 + (int'(sh) + 3) / 4); else n_pass++;
            n_checks++; if (lb != 1 + int'(sh)) $display("FAIL sweep%0d_s1_latency got %0d want %0d", t, lb, 1 + int'(sh)); else n_pass++;
            n_checks++; if (lc != ((sh > 0) ? 2 : 1)) $display("FAIL sweep%0d_s32_latency got %0d want %0d", t, lc, (sh > 0) ? 2 : 1); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
